// File: rtl/g_matched_filter_accumulator.sv
// Matched filter z = G^H * y for the four 4x2 G matrices (Ga1, Ga2, Gb1, Gb2).
// Loads a 4-sample y vector, then accumulates conj(g)*y[row] over 4 G rows.
module g_matched_filter_accumulator #(
    parameter  int N     = 16,
    localparam int ACC_W = 2*N+3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    y_in_valid,
    input  logic signed [N-1:0]     y_in_r,
    input  logic signed [N-1:0]     y_in_i,
    input  logic                    G_row_valid,
    input  logic signed [N-1:0]     Ga1_c0_r,
    input  logic signed [N-1:0]     Ga1_c0_i,
    input  logic signed [N-1:0]     Ga1_c1_r,
    input  logic signed [N-1:0]     Ga1_c1_i,
    input  logic signed [N-1:0]     Ga2_c0_r,
    input  logic signed [N-1:0]     Ga2_c0_i,
    input  logic signed [N-1:0]     Ga2_c1_r,
    input  logic signed [N-1:0]     Ga2_c1_i,
    input  logic signed [N-1:0]     Gb1_c0_r,
    input  logic signed [N-1:0]     Gb1_c0_i,
    input  logic signed [N-1:0]     Gb1_c1_r,
    input  logic signed [N-1:0]     Gb1_c1_i,
    input  logic signed [N-1:0]     Gb2_c0_r,
    input  logic signed [N-1:0]     Gb2_c0_i,
    input  logic signed [N-1:0]     Gb2_c1_r,
    input  logic signed [N-1:0]     Gb2_c1_i,
    output logic                    z_valid,
    output logic signed [ACC_W-1:0] za1_0_r,
    output logic signed [ACC_W-1:0] za1_0_i,
    output logic signed [ACC_W-1:0] za1_1_r,
    output logic signed [ACC_W-1:0] za1_1_i,
    output logic signed [ACC_W-1:0] za2_0_r,
    output logic signed [ACC_W-1:0] za2_0_i,
    output logic signed [ACC_W-1:0] za2_1_r,
    output logic signed [ACC_W-1:0] za2_1_i,
    output logic signed [ACC_W-1:0] zb1_0_r,
    output logic signed [ACC_W-1:0] zb1_0_i,
    output logic signed [ACC_W-1:0] zb1_1_r,
    output logic signed [ACC_W-1:0] zb1_1_i,
    output logic signed [ACC_W-1:0] zb2_0_r,
    output logic signed [ACC_W-1:0] zb2_0_i,
    output logic signed [ACC_W-1:0] zb2_1_r,
    output logic signed [ACC_W-1:0] zb2_1_i,
    output logic                    err,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_YLOAD, S_ACC} state_t;

    state_t                  state;
    logic [1:0]              y_cnt;
    logic [1:0]              row_cnt;
    logic signed [N-1:0]     ybuf_r [4];
    logic signed [N-1:0]     ybuf_i [4];
    logic signed [N-1:0]     g_r [8];
    logic signed [N-1:0]     g_i [8];
    logic signed [ACC_W-1:0] acc_r [8];
    logic signed [ACC_W-1:0] acc_i [8];
    logic signed [ACC_W-1:0] p_r [8];
    logic signed [ACC_W-1:0] p_i [8];
    logic signed [ACC_W-1:0] z_r [8];
    logic signed [ACC_W-1:0] z_i [8];
    logic signed [N-1:0]     yr_r;
    logic signed [N-1:0]     yr_i;

    // Lane order: Ga1 c0/c1, Ga2 c0/c1, Gb1 c0/c1, Gb2 c0/c1
    assign g_r[0] = Ga1_c0_r;  assign g_i[0] = Ga1_c0_i;
    assign g_r[1] = Ga1_c1_r;  assign g_i[1] = Ga1_c1_i;
    assign g_r[2] = Ga2_c0_r;  assign g_i[2] = Ga2_c0_i;
    assign g_r[3] = Ga2_c1_r;  assign g_i[3] = Ga2_c1_i;
    assign g_r[4] = Gb1_c0_r;  assign g_i[4] = Gb1_c0_i;
    assign g_r[5] = Gb1_c1_r;  assign g_i[5] = Gb1_c1_i;
    assign g_r[6] = Gb2_c0_r;  assign g_i[6] = Gb2_c0_i;
    assign g_r[7] = Gb2_c1_r;  assign g_i[7] = Gb2_c1_i;

    assign za1_0_r = z_r[0];  assign za1_0_i = z_i[0];
    assign za1_1_r = z_r[1];  assign za1_1_i = z_i[1];
    assign za2_0_r = z_r[2];  assign za2_0_i = z_i[2];
    assign za2_1_r = z_r[3];  assign za2_1_i = z_i[3];
    assign zb1_0_r = z_r[4];  assign zb1_0_i = z_i[4];
    assign zb1_1_r = z_r[5];  assign zb1_1_i = z_i[5];
    assign zb2_0_r = z_r[6];  assign zb2_0_i = z_i[6];
    assign zb2_1_r = z_r[7];  assign zb2_1_i = z_i[7];

    assign yr_r = ybuf_r[row_cnt];
    assign yr_i = ybuf_i[row_cnt];

    // conj(g)*y in full precision; each sum fits 2N+1 bits, sign-extended to ACC_W
    for (genvar k = 0; k < 8; k++) begin : g_lane
        logic signed [2*N-1:0] rr, ii, ri, ir;
        assign rr     = g_r[k] * yr_r;
        assign ii     = g_i[k] * yr_i;
        assign ri     = g_r[k] * yr_i;
        assign ir     = g_i[k] * yr_r;
        assign p_r[k] = ACC_W'(rr) + ACC_W'(ii);
        assign p_i[k] = ACC_W'(ri) - ACC_W'(ir);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            y_cnt   <= '0;
            row_cnt <= '0;
            z_valid <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ybuf_r[i] <= '0;
                ybuf_i[i] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                acc_r[k] <= '0;
                acc_i[k] <= '0;
                z_r[k]   <= '0;
                z_i[k]   <= '0;
            end
        end else begin
            z_valid <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (G_row_valid) err <= 1'b1;
                    if (y_in_valid) begin
                        ybuf_r[0] <= y_in_r;
                        ybuf_i[0] <= y_in_i;
                        y_cnt     <= 2'd1;
                        busy      <= 1'b1;
                        state     <= S_YLOAD;
                    end
                end
                S_YLOAD: begin
                    if (G_row_valid) err <= 1'b1;
                    if (y_in_valid) begin
                        ybuf_r[y_cnt] <= y_in_r;
                        ybuf_i[y_cnt] <= y_in_i;
                        y_cnt         <= y_cnt + 2'd1;
                        if (y_cnt == 2'd3) begin
                            for (int k = 0; k < 8; k++) begin
                                acc_r[k] <= '0;
                                acc_i[k] <= '0;
                            end
                            row_cnt <= '0;
                            state   <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (G_row_valid) begin
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'd3) begin
                            // Final row goes straight to the outputs; acc is cleared on the next y load
                            for (int k = 0; k < 8; k++) begin
                                z_r[k] <= acc_r[k] + p_r[k];
                                z_i[k] <= acc_i[k] + p_i[k];
                            end
                            z_valid <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            for (int k = 0; k < 8; k++) begin
                                acc_r[k] <= acc_r[k] + p_r[k];
                                acc_i[k] <= acc_i[k] + p_i[k];
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
